// File: rtl/div_32bit_seq.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH clocks per op.
// start pulses in; busy covers the iterations; done pulses one cycle with registered results.
module div_32bit_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic             zdiv_q, zdiv_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH-1:0] diff;
  logic             fits;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;
  logic             last_iter;

  // Trial compare at WIDTH+1 bits; when it fits the difference is < divisor,
  // so the low WIDTH bits of the subtraction are exact.
  always_comb begin
    p_shift   = {p_q, q_q[WIDTH-1]};
    fits      = (p_shift >= {1'b0, dvs_q});
    diff      = p_shift[WIDTH-1:0] - dvs_q;
    p_next    = fits ? diff : p_shift[WIDTH-1:0];
    q_next    = {q_q[WIDTH-2:0], fits};
    last_iter = (cnt_q == CNT_W'(WIDTH-1));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    zdiv_d  = zdiv_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // A zero divisor takes one silent pass through RUN (busy low, no
          // iterations) so that done lands one edge after the start edge.
          state_d = RUN;
          dvs_d   = divisor;
          q_d     = dividend;
          p_d     = '0;
          cnt_d   = '0;
          zdiv_d  = (divisor == '0);
          busy_d  = (divisor != '0);
        end
      end
      RUN: begin
        if (zdiv_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          quo_d   = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          zdiv_d  = 1'b0;
        end else begin
          p_d   = p_next;
          q_d   = q_next;
          cnt_d = cnt_q + 1'b1;
          if (last_iter) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            quo_d   = q_next;
            rem_d   = p_next;
            dbz_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      zdiv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      zdiv_q  <= zdiv_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_32bit_seq.sv
// Directed and randomized checks for div_32bit_seq: results, latency, zero divisor,
// ignored/back-to-back starts and asynchronous reset abort.
module tb_div_32bit_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  div_32bit_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a start for one edge (E0); returns 1ns after E0.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Number of edges after E0 until done is seen; -1 on timeout. Records busy&done overlap.
  task automatic wait_done(output int lat, output logic overlap);
    lat = -1;
    overlap = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (busy && done) overlap = 1'b1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat; logic ov;
    issue(32'd100, 32'd7);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL basic_busy_after_start: busy=%b done=%b, want 1 0", busy, done);
    end
    wait_done(lat, ov);
    checks++;
    if (lat !== 32 || ov !== 1'b0) begin
      errors++; $display("FAIL basic_latency: lat=%0d overlap=%b, want 32 0", lat, ov);
    end
    checks++;
    if (quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL basic_result: q=%0d r=%0d dbz=%b, want 14 2 0",
                         quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done_pulse: done=%b busy=%b after done cycle, want 0 0", done, busy);
    end
  endtask

  task automatic test_boundary();
    int lat; logic ov;
    issue(32'hFFFF_FFFF, 32'd1);
    wait_done(lat, ov);
    checks++;
    if (lat !== 32 || quotient !== 32'hFFFF_FFFF || remainder !== 32'd0) begin
      errors++; $display("FAIL max_div_1: lat=%0d q=%h r=%h, want 32 ffffffff 0", lat, quotient, remainder);
    end
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, ov);
    checks++;
    if (lat !== 32 || quotient !== 32'd0 || remainder !== 32'h8000_0000) begin
      errors++; $display("FAIL msb_div_max: lat=%0d q=%h r=%h, want 32 0 80000000", lat, quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int lat; logic ov;
    issue(32'd5, 32'd0);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL dz_after_start: busy=%b done=%b, want 0 0", busy, done);
    end
    wait_done(lat, ov);
    checks++;
    if (lat !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL dz_latency: lat=%0d busy=%b, want 1 0", lat, busy);
    end
    checks++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_by_zero !== 1'b1) begin
      errors++; $display("FAIL dz_result: q=%h r=%0d dbz=%b, want ffffffff 5 1",
                         quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    issue(32'd3, 32'd10);
    checks++;
    if (div_by_zero !== 1'b1 || quotient !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL dz_hold_on_start: dbz=%b q=%h, want 1 ffffffff", div_by_zero, quotient);
    end
    wait_done(lat, ov);
    checks++;
    if (lat !== 32 || quotient !== 32'd0 || remainder !== 32'd3 || div_by_zero !== 1'b0) begin
      errors++; $display("FAIL dz_clear: lat=%0d q=%0d r=%0d dbz=%b, want 32 0 3 0",
                         lat, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_start_ignored();
    int lat = -1;
    issue(32'd1000, 32'd3);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 10) begin start = 1'b1; dividend = 32'd9; divisor = 32'd9; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    start = 1'b0;
    checks++;
    if (lat !== 32 || quotient !== 32'd333 || remainder !== 32'd1) begin
      errors++; $display("FAIL start_ignored: lat=%0d q=%0d r=%0d, want 32 333 1", lat, quotient, remainder);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic ov;
    // Still in the done cycle of 1000/3: request 9/9 here.
    start = 1'b1; dividend = 32'd9; divisor = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || quotient !== 32'd333 || remainder !== 32'd1) begin
      errors++; $display("FAIL b2b_accept: busy=%b done=%b q=%0d r=%0d, want 1 0 333 1",
                         busy, done, quotient, remainder);
    end
    wait_done(lat, ov);
    checks++;
    if (lat !== 32 || ov !== 1'b0 || quotient !== 32'd1 || remainder !== 32'd0) begin
      errors++; $display("FAIL b2b_result: lat=%0d ov=%b q=%0d r=%0d, want 32 0 1 0",
                         lat, ov, quotient, remainder);
    end
  endtask

  task automatic test_async_reset();
    int lat; logic ov; logic saw_done = 1'b0;
    issue(32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++; $display("FAIL async_reset: busy=%b done=%b dbz=%b q=%h r=%h, want all zero",
                         busy, done, div_by_zero, quotient, remainder);
    end
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++; $display("FAIL reset_abort: activity after abort=%b, want 0", saw_done);
    end
    issue(32'd100, 32'd7);
    wait_done(lat, ov);
    checks++;
    if (lat !== 32 || quotient !== 32'd14 || remainder !== 32'd2) begin
      errors++; $display("FAIL post_reset_op: lat=%0d q=%0d r=%0d, want 32 14 2", lat, quotient, remainder);
    end
  endtask

  task automatic test_random();
    int lat; logic ov;
    logic [31:0] a, b;
    logic [63:0] recon;
    for (int k = 0; k < 1000; k++) begin
      a = $urandom;
      case (k % 5)
        0: b = 32'd1;
        1: begin a = a >> (k % 31); b = a + 32'd1 + ($urandom & 32'hFF); if (b == 0) b = 32'd1; end
        2: begin if (a == 0) a = 32'd1; b = a; end
        3: b = ($urandom & 32'hFFFF) + 32'd1;
        default: begin b = $urandom >> (k % 32); if (b == 0) b = 32'd3; end
      endcase
      issue(a, b);
      wait_done(lat, ov);
      recon = 64'(quotient) * 64'(b) + 64'(remainder);
      checks++;
      if (lat !== 32 || ov !== 1'b0 || recon !== 64'(a) || remainder >= b ||
          quotient !== a / b || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL random_op %0d: %h/%h lat=%0d q=%h r=%h, want lat 32 q=%h r=%h",
                 k, a, b, lat, quotient, remainder, a / b, a % b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
